// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM slave memory and the benches that drive it.
package avalon_pkg;

    // Wait counter width; covers WAITCYCLES up to 15.
    localparam int WCNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // Data bus width in bits for a given number of byte lanes.
    function automatic int data_width(input int nbytes);
        return 8 * nbytes;
    endfunction

    // Number of memory words addressable with the given word-address width.
    function automatic int mem_depth(input int nbits);
        return 1 << nbits;
    endfunction

endpackage

// File: rtl/avalon_rd_pipe.sv
// Fixed-latency valid+data delay line for read responses.
// The data of each stage only loads alongside a valid entry, so the last stage
// keeps presenting the most recent read result while no response is due.
module avalon_rd_pipe #(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [DW-1:0]    dat [DEPTH];

    // Shift valid flags every cycle; move data only with a valid entry; clear drops in-flight reads.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat[k] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) begin
                    dat[k] <= dat[k-1];
                end
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave backed by a word memory: programmable waitrequest stall per command,
// fixed-latency pipelined reads, and a pulse flag for master protocol violations.
module avalon_slave_mem
    import avalon_pkg::*;
#(
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8,
    parameter int WAITCYCLES  = 1,
    parameter int READDELAY   = 2,
    localparam int DW         = data_width(NBDATABYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NBADDRBITS-1:0]  address,
    input  logic [NBDATABYTES-1:0] byteenable,
    input  logic [DW-1:0]          writedata,
    input  logic                   read,
    input  logic                   write,
    output logic [DW-1:0]          readdata,
    output logic                   waitrequest,
    output logic                   readdatavalid,
    output logic                   protocol_err
);

    localparam int                DEPTH = mem_depth(NBADDRBITS);
    localparam logic [WCNT_W-1:0] WC    = WCNT_W'(WAITCYCLES);

    state_t                 state, state_next;
    logic [WCNT_W-1:0]      wcnt, wcnt_next;
    logic                   cmd;
    logic                   accept;
    logic                   err_next;
    logic                   changed;

    logic [NBADDRBITS-1:0]  prev_address;
    logic [NBDATABYTES-1:0] prev_byteenable;
    logic [DW-1:0]          prev_writedata;
    logic                   prev_read;
    logic                   prev_write;

    logic [DW-1:0]          mem [DEPTH];
    logic                   rd_push;
    logic [DW-1:0]          rd_sample;

    assign cmd       = read | write;
    assign changed   = (address    != prev_address)    |
                       (byteenable != prev_byteenable) |
                       (writedata  != prev_writedata)  |
                       (read       != prev_read)       |
                       (write      != prev_write);
    // A simultaneous read+write is treated as a write; the read half never enters the pipe.
    assign rd_push   = accept & read & ~write;
    assign rd_sample = mem[address];

    // State, wait counter and registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wcnt         <= '0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_next;
            wcnt         <= wcnt_next;
            protocol_err <= err_next;
        end
    end

    // Previous-cycle copy of the command bus, used to detect a master changing a stalled command.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_address    <= '0;
            prev_byteenable <= '0;
            prev_writedata  <= '0;
            prev_read       <= 1'b0;
            prev_write      <= 1'b0;
        end else begin
            prev_address    <= address;
            prev_byteenable <= byteenable;
            prev_writedata  <= writedata;
            prev_read       <= read;
            prev_write      <= write;
        end
    end

    // Next-state, waitrequest, acceptance and protocol checking.
    always_comb begin
        state_next  = state;
        wcnt_next   = wcnt;
        waitrequest = 1'b0;
        err_next    = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                waitrequest = cmd & (WC != '0);
                if (waitrequest) begin
                    state_next = STALL;
                    wcnt_next  = WCNT_W'(1);
                end
            end
            STALL: begin
                waitrequest = cmd & (wcnt != WC);
                if (!cmd) begin
                    state_next = IDLE;
                    wcnt_next  = '0;
                    err_next   = 1'b1;
                end else begin
                    if (changed) begin
                        err_next = 1'b1;
                    end
                    if (waitrequest) begin
                        wcnt_next = wcnt + WCNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                wcnt_next  = '0;
            end
        endcase
        accept = cmd & ~waitrequest;
        if (accept) begin
            state_next = IDLE;
            wcnt_next  = '0;
            if (read && write) begin
                err_next = 1'b1;
            end
        end
    end

    // Memory array: cleared on reset, byte-lane writes on accepted write commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && write) begin
            for (int i = 0; i < NBDATABYTES; i++) begin
                if (byteenable[i]) begin
                    mem[address][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    avalon_rd_pipe #(
        .DW    (DW),
        .DEPTH (READDELAY)
    ) u_rd_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (rd_push),
        .in_data   (rd_sample),
        .out_valid (readdatavalid),
        .out_data  (readdata)
    );

endmodule

// File: tb/tb_avalon_slave_mem.sv
// Bench for avalon_slave_mem: one instance with a 1-cycle stall, one with no stall,
// both with 2-cycle read latency, checked against a plain array model of memory.
module tb_avalon_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  address = '0;
    logic [1:0]  byteenable = '0;
    logic [15:0] writedata = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
    logic        protocol_err;

    logic [7:0]  address0 = '0;
    logic [1:0]  byteenable0 = '0;
    logic [15:0] writedata0 = '0;
    logic        read0 = 1'b0;
    logic        write0 = 1'b0;
    logic [15:0] readdata0;
    logic        waitrequest0;
    logic        readdatavalid0;
    logic        protocol_err0;

    logic [15:0] m1 [256];
    logic [15:0] m0 [256];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avalon_slave_mem #(
        .NBDATABYTES (2), .NBADDRBITS (8), .WAITCYCLES (1), .READDELAY (2)
    ) dut (
        .clk (clk), .rst (rst), .address (address), .byteenable (byteenable),
        .writedata (writedata), .read (read), .write (write), .readdata (readdata),
        .waitrequest (waitrequest), .readdatavalid (readdatavalid), .protocol_err (protocol_err)
    );

    avalon_slave_mem #(
        .NBDATABYTES (2), .NBADDRBITS (8), .WAITCYCLES (0), .READDELAY (2)
    ) dut0 (
        .clk (clk), .rst (rst), .address (address0), .byteenable (byteenable0),
        .writedata (writedata0), .read (read0), .write (write0), .readdata (readdata0),
        .waitrequest (waitrequest0), .readdatavalid (readdatavalid0), .protocol_err (protocol_err0)
    );

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    // One command on dut: hold until accepted, then sample the cycle after and release the bus.
    task automatic bus_cmd(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [1:0] be, input logic [15:0] wd,
                           output int stalls, output logic err_after,
                           output logic rdv_after, output logic [15:0] rdd_after);
        logic timed_out;
        @(negedge clk);
        read = rd; write = wr; address = addr; byteenable = be; writedata = wd;
        stalls = 0;
        timed_out = 1'b0;
        #1;
        while (waitrequest) begin
            stalls++;
            if (stalls > 20) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL accept_timeout: got stalls %0d required acceptance", stalls);
        end
        @(negedge clk);
        err_after = protocol_err;
        rdv_after = readdatavalid;
        rdd_after = readdata;
        read = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [15:0] data, output int lat,
                           output int stalls, output logic err);
        logic        rdv;
        logic [15:0] rdd;
        bus_cmd(1'b1, 1'b0, addr, 2'b00, 16'h0000, stalls, err, rdv, rdd);
        lat = 0;
        data = rdd;
        if (rdv) begin
            lat = 1;
        end else begin
            for (int k = 2; k <= 10; k++) begin
                @(negedge clk);
                if (readdatavalid) begin
                    lat = k;
                    data = readdata;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m1[i] = '0;
            m0[i] = '0;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({waitrequest, readdatavalid, protocol_err} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b required 000",
                     {waitrequest, readdatavalid, protocol_err});
        end
        n_cmp++;
        if (readdata !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_readdata: got %h required 0000", readdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int stalls, lat;
        logic err, rdv;
        logic [15:0] rdd, data;
        bus_cmd(1'b0, 1'b1, 8'h10, 2'b11, 16'hBEEF, stalls, err, rdv, rdd);
        m1[8'h10] = merge(m1[8'h10], 16'hBEEF, 2'b11);
        n_cmp++;
        if (stalls !== 1) begin
            n_fail++;
            $display("[TB] FAIL write_stalls: got %0d required 1", stalls);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL write_err: got %b required 0", err);
        end
        do_read(8'h10, data, lat, stalls, err);
        n_cmp++;
        if (lat !== 2) begin
            n_fail++;
            $display("[TB] FAIL read_latency: got %0d required 2", lat);
        end
        n_cmp++;
        if (data !== m1[8'h10]) begin
            n_fail++;
            $display("[TB] FAIL read_data: got %h required %h", data, m1[8'h10]);
        end
    endtask

    task automatic test_byteenable();
        int stalls, lat;
        logic err, rdv;
        logic [15:0] rdd, data;
        bus_cmd(1'b0, 1'b1, 8'h10, 2'b01, 16'h1234, stalls, err, rdv, rdd);
        m1[8'h10] = merge(m1[8'h10], 16'h1234, 2'b01);
        do_read(8'h10, data, lat, stalls, err);
        n_cmp++;
        if (data !== 16'hBE34) begin
            n_fail++;
            $display("[TB] FAIL be_low_lane: got %h required BE34", data);
        end
        bus_cmd(1'b0, 1'b1, 8'h10, 2'b00, 16'hFFFF, stalls, err, rdv, rdd);
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL be_zero_err: got %b required 0", err);
        end
        do_read(8'h10, data, lat, stalls, err);
        n_cmp++;
        if (data !== m1[8'h10]) begin
            n_fail++;
            $display("[TB] FAIL be_zero_data: got %h required %h", data, m1[8'h10]);
        end
    endtask

    task automatic test_random();
        int stalls, lat;
        logic err, rdv;
        logic [15:0] rdd, data, wd;
        logic [7:0]  a;
        logic [1:0]  be;
        for (int n = 0; n < 40; n++) begin
            a  = 8'($urandom_range(0, 15));
            be = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                bus_cmd(1'b0, 1'b1, a, be, wd, stalls, err, rdv, rdd);
                m1[a] = merge(m1[a], wd, be);
            end else begin
                do_read(a, data, lat, stalls, err);
                n_cmp++;
                if (data !== m1[a] || lat !== 2) begin
                    n_fail++;
                    $display("[TB] FAIL rand_read @%h: got %h lat %0d required %h lat 2",
                             a, data, lat, m1[a]);
                end
            end
            n_cmp++;
            if (stalls !== 1 || err !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rand_handshake #%0d: got stalls %0d err %b required 1 0",
                         n, stalls, err);
            end
        end
    endtask

    task automatic test_stall_change();
        @(negedge clk);
        read = 1'b1; address = 8'h20;
        #1;
        n_cmp++;
        if (waitrequest !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_wait: got %b required 1", waitrequest);
        end
        @(negedge clk);
        address = 8'h21;
        @(negedge clk);
        n_cmp++;
        if (protocol_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL addr_change_err: got %b required 1", protocol_err);
        end
        read = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (protocol_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL addr_change_pulse: got %b required 0", protocol_err);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_drop_stall();
        int rdv_seen;
        @(negedge clk);
        read = 1'b1; address = 8'h10;
        @(negedge clk);
        read = 1'b0;
        rdv_seen = 0;
        @(negedge clk);
        n_cmp++;
        if (protocol_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drop_err: got %b required 1", protocol_err);
        end
        if (readdatavalid) rdv_seen++;
        @(negedge clk);
        n_cmp++;
        if (protocol_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drop_pulse: got %b required 0", protocol_err);
        end
        for (int k = 0; k < 4; k++) begin
            if (readdatavalid) rdv_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (rdv_seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL drop_no_data: got %0d responses required 0", rdv_seen);
        end
    endtask

    task automatic test_read_write_both();
        int stalls, lat, rdv_seen;
        logic err, rdv;
        logic [15:0] rdd, data;
        bus_cmd(1'b1, 1'b1, 8'h33, 2'b11, 16'hA5C3, stalls, err, rdv, rdd);
        m1[8'h33] = merge(m1[8'h33], 16'hA5C3, 2'b11);
        n_cmp++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rw_err: got %b required 1", err);
        end
        rdv_seen = rdv ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (readdatavalid) rdv_seen++;
        end
        n_cmp++;
        if (rdv_seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL rw_no_read: got %0d responses required 0", rdv_seen);
        end
        do_read(8'h33, data, lat, stalls, err);
        n_cmp++;
        if (data !== m1[8'h33]) begin
            n_fail++;
            $display("[TB] FAIL rw_write_done: got %h required %h", data, m1[8'h33]);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                write0 = 1'b1; address0 = 8'(c); byteenable0 = 2'b11; writedata0 = 16'($urandom);
                m0[c] = writedata0;
                #1;
                n_cmp++;
                if (waitrequest0 !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_write_wait %0d: got %b required 0", c, waitrequest0);
                end
            end else begin
                write0 = 1'b0;
            end
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_v = (c >= 2 && c <= 5);
            n_cmp++;
            if (readdatavalid0 !== exp_v || protocol_err0 !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL b2b_valid cyc %0d: got %b err %b required %b err 0",
                         c, readdatavalid0, protocol_err0, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (readdata0 !== m0[c-2]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_data cyc %0d: got %h required %h", c, readdata0, m0[c-2]);
                end
            end
            if (c < 4) begin
                read0 = 1'b1; address0 = 8'(c);
            end else begin
                read0 = 1'b0;
            end
        end
    endtask

    task automatic test_reset_flush();
        int stalls, lat, rdv_seen;
        logic err, rdv;
        logic [15:0] rdd, data;
        bus_cmd(1'b0, 1'b1, 8'h44, 2'b11, 16'h5A5A, stalls, err, rdv, rdd);
        bus_cmd(1'b1, 1'b0, 8'h44, 2'b00, 16'h0000, stalls, err, rdv, rdd);
        rst = 1'b1;
        rdv_seen = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (readdatavalid) rdv_seen++;
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (readdatavalid) rdv_seen++;
        end
        n_cmp++;
        if (rdv_seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL flush_dut: got %0d responses required 0", rdv_seen);
        end
        for (int i = 0; i < 256; i++) begin
            m1[i] = '0;
            m0[i] = '0;
        end
        do_read(8'h44, data, lat, stalls, err);
        n_cmp++;
        if (data !== m1[8'h44] || lat !== 2) begin
            n_fail++;
            $display("[TB] FAIL flush_mem_cleared: got %h lat %0d required %h lat 2",
                     data, lat, m1[8'h44]);
        end

        // Two reads accepted back to back on the zero-wait instance, then reset.
        @(negedge clk);
        read0 = 1'b1; address0 = 8'h01;
        @(negedge clk);
        address0 = 8'h02;
        @(negedge clk);
        read0 = 1'b0;
        rst = 1'b1;
        rdv_seen = 0;
        @(negedge clk);
        if (readdatavalid0) rdv_seen++;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (readdatavalid0) rdv_seen++;
        end
        n_cmp++;
        if (rdv_seen !== 0 || readdata0 !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL flush_dut0: got %0d responses data %h required 0 data 0000",
                     rdv_seen, readdata0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_random();
        test_stall_change();
        test_drop_stall();
        test_read_write_both();
        test_back_to_back();
        test_reset_flush();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
